// File: rtl/cpci_reprog_target.sv
// -----------------------------------------------------------------------------
// cpci_reprog_target
//  Responder side of the CPCI reprogram register path. Takes REPROG_CTRL and
//  REPROG_DATA writes from the PCI target decode, buffers 32-bit words in a
//  small FIFO and plays them out MSB byte first on a Virtex byte-wide SelectMAP
//  port with a divided CCLK. Busy/done/error status is exposed for readback.
//
//  Optional feature macro: REPROG_BIT_SWAP_EN
//    defined   : each byte is bit-reversed onto rp_data (word bit 31 -> rp_data[0])
//    undefined : rp_data[7:0] carries the byte bits [7:0] unchanged
//
//  Ports
//   clk, reset             system clock, asynchronous active-high reset
//   ctrl_wr, data_wr       1-cycle write strobes (REPROG_CTRL / REPROG_DATA)
//   wr_data[31:0]          write data; wr_data[0]=1 on ctrl_wr starts/restarts
//   fifo_full              word FIFO full
//   reprog_busy            sequence in progress (not IDLE/DONE/ERROR)
//   reprog_done            sticky, target DONE observed
//   reprog_error           sticky, CRC error / INIT timeout / FIFO overflow
//   rp_prog_b, rp_cs_b,    SelectMAP control pins (active low)
//   rp_rdwr_b
//   rp_cclk, rp_data[7:0]  configuration clock and byte
//   rp_init_b, rp_done     target status pins (synchronised internally)
// -----------------------------------------------------------------------------
module cpci_reprog_target #(
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CCLK_DIV        = 2,
   parameter int PROG_CYCLES     = 64,
   parameter int INIT_TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ctrl_wr,
   input  logic        data_wr,
   input  logic [31:0] wr_data,
   output logic        fifo_full,
   output logic        reprog_busy,
   output logic        reprog_done,
   output logic        reprog_error,
   output logic        rp_prog_b,
   output logic        rp_cs_b,
   output logic        rp_rdwr_b,
   output logic        rp_cclk,
   output logic [7:0]  rp_data,
   input  logic        rp_init_b,
   input  logic        rp_done
);

   localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
   localparam int CNT_MAX = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PROG_LOW, S_WAIT_INIT, S_LOAD, S_SHIFT, S_DONE, S_ERROR
   } state_t;

   state_t state, state_next;

   // Byte lane mapping onto the SelectMAP data pins.
   function automatic logic [7:0] map_byte(input logic [7:0] b);
`ifdef REPROG_BIT_SWAP_EN
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
`else
      return b;
`endif
   endfunction

   // ---------------------------------------------------------------- sync
   logic init_meta, init_sync, done_meta, done_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_meta <= 1'b0;
         init_sync <= 1'b0;
         done_meta <= 1'b0;
         done_sync <= 1'b0;
      end else begin
         init_meta <= rp_init_b;
         init_sync <= init_meta;
         done_meta <= rp_done;
         done_sync <= done_meta;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [31:0]              mem [DEPTH];
   logic [FIFO_DEPTH_BITS:0] wr_ptr, rd_ptr;
   logic [31:0]              fifo_head;
   logic                     fifo_empty, start, accepting, push, pop, overflow;

   assign start      = ctrl_wr && wr_data[0];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FIFO_DEPTH_BITS] != rd_ptr[FIFO_DEPTH_BITS]) &&
                       (wr_ptr[FIFO_DEPTH_BITS-1:0] == rd_ptr[FIFO_DEPTH_BITS-1:0]);
   assign fifo_head  = mem[rd_ptr[FIFO_DEPTH_BITS-1:0]];

   assign accepting  = (state == S_PROG_LOW) || (state == S_WAIT_INIT) ||
                       (state == S_LOAD)     || (state == S_SHIFT);
   // Pop is decided before push so a full FIFO being drained still takes the word.
   assign pop        = (state == S_LOAD) && !done_sync && !fifo_empty && !start;
   assign push       = data_wr && accepting && !start && (!fifo_full || pop);
   assign overflow   = data_wr && accepting && !start && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ---------------------------------------------------------------- FSM
   logic [CNT_W-1:0] cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       byte_idx;
   logic [31:0]      shift;
   logic             done_pend, done_flag, err_flag;
   logic             div_end;

   assign div_end = (div_cnt == DIV_W'(CCLK_DIV - 1));

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = S_PROG_LOW;
      end else begin
         case (state)
            S_PROG_LOW:  if (cnt == CNT_W'(PROG_CYCLES - 1)) state_next = S_WAIT_INIT;
            S_WAIT_INIT: begin
               if (init_sync)                             state_next = S_LOAD;
               else if (cnt == CNT_W'(INIT_TIMEOUT - 1))  state_next = S_ERROR;
            end
            S_LOAD: begin
               if (done_sync)        state_next = S_DONE;
               else if (!fifo_empty) state_next = S_SHIFT;
            end
            S_SHIFT: begin
               // INIT_B dropping mid-stream flags a CRC error; abort at once.
               if (!init_sync) begin
                  state_next = S_ERROR;
               end else if (div_end && rp_cclk) begin
                  // End of a byte (high half complete).
                  if (done_sync || done_pend) state_next = S_DONE;
                  else if (byte_idx == 2'd3)  state_next = S_LOAD;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         div_cnt   <= '0;
         byte_idx  <= 2'd0;
         shift     <= 32'd0;
         done_pend <= 1'b0;
         done_flag <= 1'b0;
         err_flag  <= 1'b0;
         rp_prog_b <= 1'b1;
         rp_cs_b   <= 1'b1;
         rp_rdwr_b <= 1'b1;
         rp_cclk   <= 1'b0;
         rp_data   <= 8'd0;
      end else begin
         state <= state_next;

         // Pins are registered from the next state so they line up with it.
         rp_prog_b <= (state_next != S_PROG_LOW);
         rp_cs_b   <= (state_next != S_SHIFT);
         rp_rdwr_b <= (state_next == S_IDLE) || (state_next == S_DONE) ||
                      (state_next == S_ERROR);

         if (start || (state_next != state))
            cnt <= '0;
         else if ((state == S_PROG_LOW) || (state == S_WAIT_INIT))
            cnt <= cnt + 1'b1;

         if (pop) begin
            // First byte goes out with CCLK low on SHIFT entry.
            shift     <= {fifo_head[23:0], 8'h00};
            rp_data   <= map_byte(fifo_head[31:24]);
            byte_idx  <= 2'd0;
            div_cnt   <= '0;
            rp_cclk   <= 1'b0;
            done_pend <= 1'b0;
         end else if ((state == S_SHIFT) && (state_next == S_SHIFT)) begin
            if (done_sync) done_pend <= 1'b1;
            if (div_end) begin
               div_cnt <= '0;
               rp_cclk <= ~rp_cclk;
               if (rp_cclk) begin
                  // Falling CCLK: present the next byte on the same edge.
                  byte_idx <= byte_idx + 2'd1;
                  rp_data  <= map_byte(shift[31:24]);
                  shift    <= {shift[23:0], 8'h00};
               end
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end else begin
            rp_cclk <= 1'b0;
            div_cnt <= '0;
         end

         if (start) begin
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            done_pend <= 1'b0;
         end else begin
            if (state_next == S_DONE)               done_flag <= 1'b1;
            if ((state_next == S_ERROR) || overflow) err_flag  <= 1'b1;
         end
      end
   end

   assign reprog_busy  = accepting;
   assign reprog_done  = done_flag;
   assign reprog_error = err_flag;

endmodule
